// File: rtl/countdown_timer.sv
// +----------------------------------------------------------------------------+
// | countdown_timer                                                            |
// | MM:SS BCD countdown with load, 1 Hz decrement, expiry pulse and alarm.     |
// | Optional macro: COUNTDOWN_PRESET_CLAMP_EN (clamp preset digits at load).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module countdown_timer #(
   parameter int ALARM_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       enable,
   input  logic       load,
   input  logic [3:0] preset_min_tens,
   input  logic [3:0] preset_min_ones,
   input  logic [3:0] preset_sec_tens,
   input  logic [3:0] preset_sec_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       timer_done,
   output logic       expired_pulse,
   output logic       alarm
);

   localparam logic [7:0] c_alarm_ticks = 8'(ALARM_TICKS);

   logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
   logic       r_expired_pulse;
   logic       r_alarm;
   logic [7:0] r_alarm_cnt;

   logic [3:0] w_ld_min_tens, w_ld_min_ones, w_ld_sec_tens, w_ld_sec_ones;
   logic [3:0] w_nx_min_tens, w_nx_min_ones, w_nx_sec_tens, w_nx_sec_ones;
   logic       w_so_borrow, w_st_borrow, w_mo_borrow;
   logic       w_zero;
   logic       w_dec;
   logic       w_expire;

`ifdef COUNTDOWN_PRESET_CLAMP_EN
   assign w_ld_min_tens = (preset_min_tens > 4'd9) ? 4'd9 : preset_min_tens;
   assign w_ld_min_ones = (preset_min_ones > 4'd9) ? 4'd9 : preset_min_ones;
   assign w_ld_sec_tens = (preset_sec_tens > 4'd5) ? 4'd5 : preset_sec_tens;
   assign w_ld_sec_ones = (preset_sec_ones > 4'd9) ? 4'd9 : preset_sec_ones;
`else
   assign w_ld_min_tens = preset_min_tens;
   assign w_ld_min_ones = preset_min_ones;
   assign w_ld_sec_tens = preset_sec_tens;
   assign w_ld_sec_ones = preset_sec_ones;
`endif

   assign w_zero = (r_min_tens == 4'd0) && (r_min_ones == 4'd0) &&
                   (r_sec_tens == 4'd0) && (r_sec_ones == 4'd0);

   // Borrow chain; out-of-range digits still just step down by one when nonzero.
   always_comb begin
      w_so_borrow   = (r_sec_ones == 4'd0);
      w_st_borrow   = w_so_borrow && (r_sec_tens == 4'd0);
      w_mo_borrow   = w_st_borrow && (r_min_ones == 4'd0);
      w_nx_sec_ones = w_so_borrow ? 4'd9 : r_sec_ones - 4'd1;
      w_nx_sec_tens = r_sec_tens;
      w_nx_min_ones = r_min_ones;
      w_nx_min_tens = r_min_tens;
      if (w_so_borrow)
         w_nx_sec_tens = (r_sec_tens == 4'd0) ? 4'd5 : r_sec_tens - 4'd1;
      if (w_st_borrow)
         w_nx_min_ones = (r_min_ones == 4'd0) ? 4'd9 : r_min_ones - 4'd1;
      if (w_mo_borrow)
         w_nx_min_tens = r_min_tens - 4'd1;
   end

   assign w_dec    = !load && enable && tick_1hz && !w_zero;
   assign w_expire = w_dec && (w_nx_min_tens == 4'd0) && (w_nx_min_ones == 4'd0) &&
                     (w_nx_sec_tens == 4'd0) && (w_nx_sec_ones == 4'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_min_tens <= 4'd0;
         r_min_ones <= 4'd0;
         r_sec_tens <= 4'd0;
         r_sec_ones <= 4'd0;
      end else if (load) begin
         r_min_tens <= w_ld_min_tens;
         r_min_ones <= w_ld_min_ones;
         r_sec_tens <= w_ld_sec_tens;
         r_sec_ones <= w_ld_sec_ones;
      end else if (w_dec) begin
         r_min_tens <= w_nx_min_tens;
         r_min_ones <= w_nx_min_ones;
         r_sec_tens <= w_nx_sec_tens;
         r_sec_ones <= w_nx_sec_ones;
      end
   end

   // Alarm ticks run off tick_1hz alone so a disabled count still times out the buzzer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_expired_pulse <= 1'b0;
         r_alarm         <= 1'b0;
         r_alarm_cnt     <= 8'd0;
      end else begin
         r_expired_pulse <= w_expire;
         if (load) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= 8'd0;
         end else if (w_expire) begin
            r_alarm     <= 1'b1;
            r_alarm_cnt <= c_alarm_ticks;
         end else if (r_alarm && tick_1hz) begin
            r_alarm_cnt <= r_alarm_cnt - 8'd1;
            if (r_alarm_cnt <= 8'd1) begin
               r_alarm     <= 1'b0;
               r_alarm_cnt <= 8'd0;
            end
         end
      end
   end

   assign min_tens      = r_min_tens;
   assign min_ones      = r_min_ones;
   assign sec_tens      = r_sec_tens;
   assign sec_ones      = r_sec_ones;
   assign timer_done    = w_zero;
   assign expired_pulse = r_expired_pulse;
   assign alarm         = r_alarm;

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Main MM:SS countdown stage, directly downstream of the egg-timer control FSM.
- Loads a BCD preset from the setting counters on `load` and decrements once per 1 Hz tick while `enable` is high.
- Drives `timer_done` back to the control FSM and the four BCD digits to the display mux.
- Generates an expiry pulse and a timed alarm output for the buzzer/LED.

Parameters:
- ALARM_TICKS, 10, number of `tick_1hz` pulses that `alarm` stays high after expiry; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1hz  in  1  single-cycle enable pulse, once per second, synchronous to clk
- enable  in  1  count enable (control FSM's main timer enable)
- load  in  1  load preset (control FSM's load strobe)
- preset_min_tens  in  4  BCD preset digit
- preset_min_ones  in  4  BCD preset digit
- preset_sec_tens  in  4  BCD preset digit
- preset_sec_ones  in  4  BCD preset digit
- min_tens  out  4  current count digit
- min_ones  out  4  current count digit
- sec_tens  out  4  current count digit
- sec_ones  out  4  current count digit
- timer_done  out  1  high whenever count == 00:00
- expired_pulse  out  1  one-cycle pulse when a decrement reaches 00:00
- alarm  out  1  high for ALARM_TICKS ticks after expiry

Behaviour:
- Reset (async): all digits 0, `expired_pulse` 0, `alarm` 0, alarm counter 0. `timer_done` = 1 because the count is zero.
- `timer_done` is combinational from the registered digits: all four digits == 0.
- Priority per rising clk edge: reset > load > decrement > hold.
- Load:
  - When `load` = 1, digits take the preset values at the next edge; `tick_1hz` and `enable` are ignored that cycle.
  - Load clears `alarm` and the alarm counter.
  - Load does not assert `expired_pulse`, even when the preset is 00:00.
- Decrement:
  - Occurs when `load` = 0, `enable` = 1, `tick_1hz` = 1 and count != 00:00.
  - Each digit is a BCD down-counter with borrow chain sec_ones → sec_tens → min_ones → min_tens.
  - sec_ones: 0 → 9 with borrow, else −1.
  - sec_tens: decremented only on borrow; 0 → 5 with borrow, else −1.
  - min_ones: decremented only on borrow; 0 → 9 with borrow, else −1.
  - min_tens: decremented only on borrow; −1 (never underflows while count != 0).
  - Latency: digits update at the edge following the tick cycle. One tick = exactly one second removed.
- Zero hold: at 00:00 a tick with `enable` high does nothing. No wrap to 99:59.
- Enable low: count freezes. Ticks arriving while disabled are dropped, not queued.
- Expiry:
  - The decrement edge that produces 00:00 registers `expired_pulse` = 1 for exactly one cycle.
  - The same edge sets `alarm` = 1 and loads the alarm counter with ALARM_TICKS.
- Alarm:
  - While `alarm` = 1, each `tick_1hz` decrements the alarm counter, independent of `enable`.
  - When the counter reaches 0, `alarm` drops at that edge.
  - A new expiry cannot occur while the count is zero; only load clears the alarm early.
- Simultaneous events:
  - `load` with a tick on the same cycle → load wins and the tick is lost.
  - `load` in the same cycle the count would have expired → load wins, no pulse, no alarm.
- Out-of-range preset digits (>9, or sec_tens > 5) without the optional feature:
  - Loaded verbatim.
  - Decrement uses the same rules (nonzero → −1), so the count remains monotonic and terminates.
- Reset mid-count returns to the reset values immediately, regardless of clk.

Optional Feature:
- Macro: COUNTDOWN_PRESET_CLAMP_EN
- Defined: at load, each preset digit is clamped before registering.
  - min_tens, min_ones, sec_ones > 9 → 9.
  - sec_tens > 5 → 5.
  - Example: preset 0xC:0xF 7:0xA loads 99:59.
- Not defined: presets are loaded verbatim as described above. No clamp logic is synthesized.

Test Plan:
- Reset, then idle 5 cycles → digits 00:00, `timer_done` = 1, `expired_pulse` = 0, `alarm` = 0.
- Load 01:00, `enable` = 1, one tick → 00:59 on the next edge, `timer_done` = 0. A further 59 ticks → 00:00, `expired_pulse` high exactly 1 cycle, `alarm` = 1.
- ALARM_TICKS = 3, after expiry apply 3 ticks → `alarm` falls on the edge after the 3rd tick. Extra ticks at 00:00 leave the count at 00:00 (no wrap).
- Load 10:00, `enable` = 0, 5 ticks → count stays 10:00. Set `enable` = 1, 1 tick → 09:59 (full borrow chain).
- Load asserted in the same cycle as a tick with count 00:01 → count = preset, no `expired_pulse`, `alarm` stays 0.
- With COUNTDOWN_PRESET_CLAMP_EN, load 0xF:0xF:0x9:0xC → 99:59. Without the macro, the same preset loads FF:9C, and one tick → FF:9B.
